// File: rtl/fpga_msg_serializer_if.sv
// Message-in / word-out bundle between cl, the serializer and the PC read FIFO.
// master is the environment side; slave is the serializer side.
interface fpga_msg_serializer_if #(
  parameter int DROP_W = 16
);
  logic [127:0]      fpga_msg;
  logic              fpga_msg_valid;
  logic              fpga_msg_overflow;
  logic [31:0]       rd_fifo_data;
  logic              rd_fifo_wren;
  logic              rd_fifo_full;
  logic              drop_clear;
  logic [DROP_W-1:0] drop_count;
  logic              dropped_sticky;

  modport master (
    output fpga_msg, fpga_msg_valid, rd_fifo_full, drop_clear,
    input  fpga_msg_overflow, rd_fifo_data, rd_fifo_wren, drop_count, dropped_sticky
  );

  modport slave (
    input  fpga_msg, fpga_msg_valid, rd_fifo_full, drop_clear,
    output fpga_msg_overflow, rd_fifo_data, rd_fifo_wren, drop_count, dropped_sticky
  );
endinterface

// File: rtl/fpga_msg_serializer.sv
// Buffers 128-bit messages from cl and emits each as four 32-bit words, LSW first.
// Messages offered while the buffer is full are dropped and counted.
module fpga_msg_serializer #(
  parameter int LOG2_DEPTH = 2,
  parameter int DROP_W     = 16
) (
  input  logic                  bus_clk,
  input  logic                  reset,
  fpga_msg_serializer_if.slave  bus
);
  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int PW    = LOG2_DEPTH + 1;

  logic [3:0][31:0]  mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [1:0]        idx_q, idx_d;
  logic [DROP_W-1:0] drop_count_q, drop_count_d;
  logic              sticky_q, sticky_d;

  logic [PW-1:0] count;
  logic          full, empty, push, drop, wren;

  // Extra pointer bit distinguishes full from empty.
  assign count = wr_ptr_q - rd_ptr_q;
  assign full  = (count == PW'(DEPTH));
  assign empty = (count == '0);
  assign push  = bus.fpga_msg_valid && !full;
  assign drop  = bus.fpga_msg_valid && full;
  assign wren  = !empty && !bus.rd_fifo_full;

  assign bus.fpga_msg_overflow = full;
  assign bus.rd_fifo_wren      = wren;
  assign bus.rd_fifo_data      = mem_q[rd_ptr_q[LOG2_DEPTH-1:0]][idx_q];
  assign bus.drop_count        = drop_count_q;
  assign bus.dropped_sticky    = sticky_q;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    idx_d        = idx_q;
    drop_count_d = drop_count_q;
    sticky_d     = sticky_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end

    if (wren) begin
      idx_d = idx_q + 2'd1;
      if (idx_q == 2'd3) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
    end

    // A drop in the same cycle as a clear restarts the count at one.
    if (drop) begin
      sticky_d = 1'b1;
      if (bus.drop_clear) begin
        drop_count_d = DROP_W'(1);
      end else if (!(&drop_count_q)) begin
        drop_count_d = drop_count_q + DROP_W'(1);
      end
    end else if (bus.drop_clear) begin
      sticky_d     = 1'b0;
      drop_count_d = '0;
    end
  end

  always_ff @(posedge bus_clk) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      idx_q        <= '0;
      drop_count_q <= '0;
      sticky_q     <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      idx_q        <= idx_d;
      drop_count_q <= drop_count_d;
      sticky_q     <= sticky_d;
    end
  end

  always_ff @(posedge bus_clk) begin
    if (push) begin
      mem_q[wr_ptr_q[LOG2_DEPTH-1:0]] <= bus.fpga_msg;
    end
  end
endmodule
